vote_collector: RTL and testbench
=================================

# vote_collector

Front-end stage for the five-input count display. Samples five raw voter buttons, synchronizes and debounces each one, and runs a voting-session state machine. Each voter's vote is latched once per session onto `c1`..`c5`, which drive the display decoder directly. The decoder shows how many of the five lines are high.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high samples required before a press is accepted.
  - Legal range 1..255.
  - Counter width is 8 bits.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  level-sampled; opens a session (see Operation).
- `close`  input  1  level-sampled; ends an open session.
- `btn`  input  5  raw asynchronous voter buttons; `btn[0]` maps to `c1`, …, `btn[4]` maps to `c5`.
- `c1`..`c5`  output  1 each  latched votes; direct inputs of the display decoder.
- `session_open`  output  1  high while in state OPEN.
- `done`  output  1  one-cycle pulse on entry to CLOSED.

## Operation

Input conditioning (per channel, runs in every state):
- Two-flop synchronizer feeds a saturating run counter.
- The counter clears on any synchronized-low sample.
- The debounced level `deb[i]` rises once the counter reaches `DEBOUNCE_CYCLES` consecutive high samples.
- `deb[i]` falls on the first synchronized-low sample.
- A press is the rising edge of `deb[i]`.

Session FSM, states IDLE, OPEN, CLOSED:
- IDLE:
  - `start` moves to OPEN and clears `c1`..`c5` to 0.
  - `close` is ignored.
- OPEN:
  - A press on channel i sets the corresponding `c` output to 1.
  - A further press on an already-voted channel has no effect.
  - `close` moves to CLOSED.
  - The edge on which all five `c` outputs become 1 also moves to CLOSED (auto-close).
  - `start` is ignored.
- CLOSED:
  - `c1`..`c5` hold their values for display.
  - `start` moves to OPEN and clears all votes.
  - `close` is ignored.

Boundary rules:
- A press and `close` on the same edge: the vote is counted, then the session closes.
- `start` and `close` together in IDLE or CLOSED: `start` wins.
- A button already debounced-high when OPEN is entered does not vote. It must be released and pressed again.
- Multiple channels pressing on the same edge are all counted.
- `rst` at any time, including mid-debounce or mid-session, forces the following:
  - state IDLE;
  - all `c` outputs 0;
  - synchronizers, counters and `deb` cleared.

## Timing

- Reset values: `c1`..`c5` = 0, `session_open` = 0, `done` = 0, state IDLE.
- All outputs are registered; there is no combinational path from input to output.
- Press latency: if `btn[i]` is first sampled high at edge k and held, the matching `c` output is 1 after edge k+2+`DEBOUNCE_CYCLES`.
- Pulses shorter than `DEBOUNCE_CYCLES` synchronized samples never register.
- `session_open` is high from the edge after `start` is sampled in IDLE or CLOSED.
- `done` is high for exactly the one cycle following the transition edge into CLOSED.
- With `close` held continuously, `done` still pulses only once per session.

## Configuration

- `VOTE_RETRACT_EN` defined:
  - In OPEN, a press on an already-voted channel clears its `c` output back to 0 (toggle behavior).
  - Auto-close is disabled; only `close` ends the session.
- `VOTE_RETRACT_EN` undefined:
  - Votes are sticky within a session.
  - Auto-close on five votes is active.

## Test plan

Unless noted, `DEBOUNCE_CYCLES` = 4 and the macro is undefined.
- Latency: `rst`, then `start`; hold `btn` = 5'b00001 from edge 10. Expect `c1` = 1 after edge 16, other `c` outputs 0, `session_open` = 1.
- Glitch rejection: in OPEN, drive `btn[2]` high for 3 cycles, then low. Expect `c3` to stay 0 and the counter to clear.
- Auto-close: press all five channels on the same edge. Expect `c1`..`c5` = 1, state CLOSED, `done` = 1 for exactly 1 cycle, `session_open` = 0.
- Close precedence: a `btn[4]` press matures on the same edge `close` is sampled. Expect `c5` = 1, CLOSED, one `done` pulse. A later press on `btn[0]` leaves `c1` = 0.
- Held button and reopen: `btn[1]` held through `start` from CLOSED with prior votes 5'b10110. Expect all `c` outputs cleared to 0 and `c2` staying 0 until a release and re-press.
- Mid-session reset and retract: assert `rst` during debounce with 2 votes latched; expect all outputs 0 and IDLE next cycle. Then with `VOTE_RETRACT_EN` defined, press `btn[3]` twice in OPEN; expect `c4` to go 1 then 0, with no auto-close.

Source files
------------

// File: rtl/vote_collector.sv
// vote_collector: debounced five-voter session front end; define VOTE_RETRACT_EN for toggle votes without auto-close
module vote_collector #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       close,
    input  logic [4:0] btn,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       session_open,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, OPEN, CLOSED} state_t;
    localparam logic [7:0] LIM = 8'(DEBOUNCE_CYCLES);
    state_t state, state_n;
    logic [4:0] s1, s2, deb, deb_q, press, votes, votes_n;
    logic [7:0] cnt [5];
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            deb_q <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            deb_q <= deb;
            for (int i = 0; i < 5; i++)
                cnt[i] <= !s2[i] ? '0 : (cnt[i] == LIM ? LIM : cnt[i] + 8'd1);
        end
    end
    for (genvar g = 0; g < 5; g++) begin : g_deb
        assign deb[g] = cnt[g] >= LIM;
    end
    // only a fresh rising edge votes, so a button held into OPEN is ignored
    assign press = deb & ~deb_q;
    always_comb begin
        state_n = state;
        votes_n = votes;
        case (state)
            IDLE, CLOSED: begin
                if (start) begin
                    state_n = OPEN;
                    votes_n = '0;
                end
            end
            OPEN: begin
`ifdef VOTE_RETRACT_EN
                votes_n = votes ^ press;
                if (close) state_n = CLOSED;
`else
                votes_n = votes | press;
                if (close || &votes_n) state_n = CLOSED;
`endif
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            votes <= '0;
            session_open <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            votes <= votes_n;
            session_open <= state_n == OPEN;
            done <= state == OPEN && state_n == CLOSED;
        end
    end
    assign {c5, c4, c3, c2, c1} = votes;
endmodule

// File: tb/tb_vote_collector.sv
// tb_vote_collector: directed checks of debounce latency, session FSM and boundary rules
module tb_vote_collector;
    logic clk = 1'b0, rst, start, close;
    logic [4:0] btn, c;
    logic c1, c2, c3, c4, c5, session_open, done;
    int n_cmp = 0, n_err = 0;

    vote_collector #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .close(close), .btn(btn),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5),
        .session_open(session_open), .done(done)
    );

    always #5 clk = ~clk;
    assign c = {c5, c4, c3, c2, c1};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; close = 1'b0; btn = '0;
        tick(2);
        chk("reset_c", 8'(c), 8'h00);
        chk("reset_open", 8'(session_open), 8'h0);
        chk("reset_done", 8'(done), 8'h0);
        rst = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        chk("start_open", 8'(session_open), 8'h1);
        chk("start_c", 8'(c), 8'h00);
        // latency: sampled at edge k, vote visible after edge k+6
        btn = 5'h01; tick(6);
        chk("lat_early", 8'(c), 8'h00);
        tick(1);
        chk("lat_c1", 8'(c), 8'h01);
        chk("lat_open", 8'(session_open), 8'h1);
        btn = '0; tick(4);
        // two 3-sample glitches split by one low sample must not vote
        btn = 5'h04; tick(3); btn = '0; tick(1);
        btn = 5'h04; tick(3); btn = '0; tick(8);
        chk("glitch_c", 8'(c), 8'h01);
        start = 1'b1; tick(1); start = 1'b0;
        chk("open_start_ign_c", 8'(c), 8'h01);
        chk("open_start_ign_open", 8'(session_open), 8'h1);
        close = 1'b1; tick(1);
        chk("close_done", 8'(done), 8'h1);
        chk("close_open", 8'(session_open), 8'h0);
        chk("close_hold_c", 8'(c), 8'h01);
        tick(2);
        chk("close_held_done", 8'(done), 8'h0);
        start = 1'b1; tick(1); start = 1'b0; close = 1'b0;
        chk("start_wins_open", 8'(session_open), 8'h1);
        chk("start_wins_c", 8'(c), 8'h00);
        chk("start_wins_done", 8'(done), 8'h0);
        btn = 5'h1f; tick(6);
        chk("all_early", 8'(c), 8'h00);
        tick(1);
        chk("all_c", 8'(c), 8'h1f);
`ifdef VOTE_RETRACT_EN
        chk("all_no_autoclose", 8'(session_open), 8'h1);
        chk("all_no_done", 8'(done), 8'h0);
        close = 1'b1; tick(1); close = 1'b0;
        chk("all_close_done", 8'(done), 8'h1);
`else
        chk("auto_open", 8'(session_open), 8'h0);
        chk("auto_done", 8'(done), 8'h1);
`endif
        tick(1);
        chk("auto_done_once", 8'(done), 8'h0);
        btn = '0; tick(4);
        // press and close on the same edge
        start = 1'b1; tick(1); start = 1'b0;
        chk("prec_clear", 8'(c), 8'h00);
        btn = 5'h10; tick(6);
        close = 1'b1; tick(1); close = 1'b0;
        chk("prec_c5", 8'(c), 8'h10);
        chk("prec_open", 8'(session_open), 8'h0);
        chk("prec_done", 8'(done), 8'h1);
        tick(1);
        chk("prec_done_once", 8'(done), 8'h0);
        btn = 5'h01; tick(8);
        chk("prec_late_press", 8'(c), 8'h10);
        btn = '0; tick(4);
        // held button across reopen
        start = 1'b1; tick(1); start = 1'b0;
        btn = 5'h16; tick(7);
        chk("prior_votes", 8'(c), 8'h16);
        btn = 5'h02; close = 1'b1; tick(1); close = 1'b0;
        chk("prior_closed", 8'(session_open), 8'h0);
        chk("prior_hold", 8'(c), 8'h16);
        start = 1'b1; tick(1); start = 1'b0;
        chk("reopen_clear", 8'(c), 8'h00);
        chk("reopen_open", 8'(session_open), 8'h1);
        tick(10);
        chk("held_no_vote", 8'(c), 8'h00);
        btn = '0; tick(4);
        btn = 5'h02; tick(6);
        chk("repress_early", 8'(c), 8'h00);
        tick(1);
        chk("repress_c2", 8'(c), 8'h02);
        // reset mid-debounce with two votes latched
        btn = 5'h01; tick(7);
        chk("two_votes", 8'(c), 8'h03);
        btn = 5'h04; tick(3);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("mid_rst_c", 8'(c), 8'h00);
        chk("mid_rst_open", 8'(session_open), 8'h0);
        chk("mid_rst_done", 8'(done), 8'h0);
        start = 1'b1; tick(1); start = 1'b0;
        chk("post_rst_open", 8'(session_open), 8'h1);
        tick(5);
        chk("post_rst_early", 8'(c), 8'h00);
        tick(1);
        chk("post_rst_vote", 8'(c), 8'h04);
        // second press on an already-voted channel
        btn = '0; tick(4);
        btn = 5'h08; tick(7);
        chk("c4_first", 8'(c), 8'h0c);
        btn = '0; tick(4);
        btn = 5'h08; tick(7);
`ifdef VOTE_RETRACT_EN
        chk("c4_retract", 8'(c), 8'h04);
`else
        chk("c4_sticky", 8'(c), 8'h0c);
`endif
        chk("c4_still_open", 8'(session_open), 8'h1);
        btn = '0;
        close = 1'b1; tick(1); close = 1'b0;
        chk("final_done", 8'(done), 8'h1);
        chk("final_open", 8'(session_open), 8'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
